// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for an NDIG-digit 7-segment display with a one-cycle guard blank at each digit change.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_mux #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  output logic [3:0]        x,
  output logic [NDIG-1:0]   an,
  output logic              slot
);

  localparam int            IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] PC_LAST  = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [4*NDIG-1:0] shadow;
  logic [CW-1:0]     pc;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_next;
  logic              live;
  logic              tick;
  logic              blank_q;

  function automatic logic [3:0] nibble(input logic [4*NDIG-1:0] v, input logic [IW-1:0] i);
    nibble = v[4*int'(i) +: 4];
  endfunction

  function automatic logic [NDIG-1:0] onehot(input logic [IW-1:0] i);
    onehot = NDIG'(1) << i;
  endfunction

  assign tick     = en && (pc == PC_LAST);
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= value;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Digit i (i >= 1) is blank when it and every more-significant nibble are zero.
  function automatic logic lz_blank(input logic [4*NDIG-1:0] v, input logic [IW-1:0] i);
    logic b;
    b = (i != '0);
    for (int k = 0; k < NDIG; k++) begin
      if (k >= int'(i) && v[4*k +: 4] != 4'h0) b = 1'b0;
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b0;
    end else if (tick) begin
      blank_q <= lz_blank(shadow, idx_next);
    end
  end
`else
  assign blank_q = 1'b0;
`endif

  // live stays low until the first tick so digit NDIG-1 is never lit before the scan starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      idx  <= IDX_LAST;
      x    <= 4'h0;
      an   <= '0;
      slot <= 1'b0;
      live <= 1'b0;
    end else if (!en) begin
      pc   <= '0;
      idx  <= IDX_LAST;
      an   <= '0;
      slot <= 1'b0;
      live <= 1'b0;
    end else if (tick) begin
      pc   <= '0;
      idx  <= idx_next;
      x    <= nibble(shadow, idx_next);
      an   <= '0;
      slot <= 1'b1;
      live <= 1'b1;
    end else begin
      pc   <= pc + CW'(1);
      slot <= 1'b0;
      an   <= (live && !blank_q) ? onehot(idx) : '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (NDIG=4, DIV=4); leading-zero cases run when SEG_SCAN_LZ_BLANK_EN is defined.
module tb_seg_scan_mux;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  x;
  logic [3:0]  an;
  logic        slot;

  int tests;
  int fails;

  seg_scan_mux #(.NDIG(4), .DIV(4), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .value (value),
    .x     (x),
    .an    (an),
    .slot  (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; load = 1'b0; value = 16'h0;
    step(); step();
    tests++; if (an !== 4'b0000 || x !== 4'h0 || slot !== 1'b0) begin fails++; $display("FAIL reset_state: got an=%b x=%h slot=%b want 0000 0 0", an, x, slot); end
    rst_n = 1'b1;
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    tests++; if (an !== 4'b0000 || slot !== 1'b0) begin fails++; $display("FAIL first_e1: got an=%b slot=%b want 0000 0", an, slot); end
    step();
    tests++; if (an !== 4'b0000 || slot !== 1'b0) begin fails++; $display("FAIL first_e2: got an=%b slot=%b want 0000 0", an, slot); end
    step();
    tests++; if (an !== 4'b0000 || slot !== 1'b0) begin fails++; $display("FAIL first_e3: got an=%b slot=%b want 0000 0", an, slot); end
    step();
    tests++; if (x !== 4'h4 || slot !== 1'b1 || an !== 4'b0000) begin fails++; $display("FAIL first_tick: got x=%h slot=%b an=%b want 4 1 0000", x, slot, an); end
    step();
    tests++; if (an !== 4'b0001 || slot !== 1'b0 || x !== 4'h4) begin fails++; $display("FAIL first_lit: got an=%b slot=%b x=%h want 0001 0 4", an, slot, x); end
  endtask

  task automatic test_full_frame();
    logic [3:0] xs [4];
    logic [3:0] ans[4];
    xs  = '{4'h3, 4'h2, 4'h1, 4'h4};
    ans = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(); step();
    tests++; if (an !== 4'b0001) begin fails++; $display("FAIL frame_d0_hold: got an=%b want 0001", an); end
    for (int s = 0; s < 4; s++) begin
      step();
      tests++; if (x !== xs[s] || slot !== 1'b1 || an !== 4'b0000) begin fails++; $display("FAIL frame_tick%0d: got x=%h slot=%b an=%b want %h 1 0000", s, x, slot, an, xs[s]); end
      step();
      tests++; if (an !== ans[s] || slot !== 1'b0 || x !== xs[s]) begin fails++; $display("FAIL frame_lit%0d: got an=%b slot=%b x=%h want %b 0 %h", s, an, slot, x, ans[s], xs[s]); end
      step(); step();
      tests++; if (an !== ans[s]) begin fails++; $display("FAIL frame_end%0d: got an=%b want %b", s, an, ans[s]); end
    end
  endtask

  task automatic test_midslot_load();
    step();
    tests++; if (x !== 4'h3 || slot !== 1'b1) begin fails++; $display("FAIL mid_tick: got x=%h slot=%b want 3 1", x, slot); end
    load = 1'b1; value = 16'hABCD;
    step();
    load = 1'b0;
    tests++; if (x !== 4'h3 || an !== 4'b0010) begin fails++; $display("FAIL mid_after_load: got x=%h an=%b want 3 0010", x, an); end
    step(); step();
    tests++; if (x !== 4'h3) begin fails++; $display("FAIL mid_hold: got x=%h want 3", x); end
    step();
    tests++; if (x !== 4'hB || slot !== 1'b1) begin fails++; $display("FAIL mid_next: got x=%h slot=%b want b 1", x, slot); end
  endtask

  task automatic test_load_tick();
    step(); step(); step();
    load = 1'b1; value = 16'h5678;
    step();
    load = 1'b0;
    tests++; if (x !== 4'hA || slot !== 1'b1) begin fails++; $display("FAIL lt_old: got x=%h slot=%b want a 1", x, slot); end
    step();
    tests++; if (an !== 4'b1000 || x !== 4'hA) begin fails++; $display("FAIL lt_lit: got an=%b x=%h want 1000 a", an, x); end
    step(); step(); step();
    tests++; if (x !== 4'h8 || slot !== 1'b1) begin fails++; $display("FAIL lt_new: got x=%h slot=%b want 8 1", x, slot); end
  endtask

  task automatic test_en_drop();
    step();
    tests++; if (an !== 4'b0001) begin fails++; $display("FAIL en_pre: got an=%b want 0001", an); end
    en = 1'b0;
    step();
    tests++; if (an !== 4'b0000 || slot !== 1'b0 || x !== 4'h8) begin fails++; $display("FAIL en_drop: got an=%b slot=%b x=%h want 0000 0 8", an, slot, x); end
    step(); step();
    tests++; if (an !== 4'b0000 || x !== 4'h8) begin fails++; $display("FAIL en_off: got an=%b x=%h want 0000 8", an, x); end
    en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      tests++; if (an !== 4'b0000 || slot !== 1'b0) begin fails++; $display("FAIL en_wait%0d: got an=%b slot=%b want 0000 0", e, an, slot); end
    end
    step();
    tests++; if (x !== 4'h8 || slot !== 1'b1 || an !== 4'b0000) begin fails++; $display("FAIL en_tick: got x=%h slot=%b an=%b want 8 1 0000", x, slot, an); end
    step();
    tests++; if (an !== 4'b0001) begin fails++; $display("FAIL en_lit: got an=%b want 0001", an); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (an !== 4'b0000 || x !== 4'h0 || slot !== 1'b0) begin fails++; $display("FAIL areset_now: got an=%b x=%h slot=%b want 0000 0 0", an, x, slot); end
    #1;
    rst_n = 1'b1;
    load = 1'b1; value = 16'h9ABC;
    step();
    load = 1'b0;
    step(); step();
    tests++; if (an !== 4'b0000 || slot !== 1'b0) begin fails++; $display("FAIL areset_wait: got an=%b slot=%b want 0000 0", an, slot); end
    step();
    tests++; if (x !== 4'hC || slot !== 1'b1) begin fails++; $display("FAIL areset_tick: got x=%h slot=%b want c 1", x, slot); end
    step();
    tests++; if (an !== 4'b0001) begin fails++; $display("FAIL areset_lit: got an=%b want 0001", an); end
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  task automatic lz_frame(input logic [15:0] v, input string tag);
    logic [3:0] xs [4];
    logic [3:0] ans[4];
    load = 1'b1; value = v;
    step();
    load = 1'b0;
    step();
    xs  = '{v[7:4], v[11:8], v[15:12], v[3:0]};
    ans = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    for (int s = 0; s < 4; s++) begin
      step();
      tests++; if (x !== xs[s] || slot !== 1'b1) begin fails++; $display("FAIL %s_tick%0d: got x=%h slot=%b want %h 1", tag, s, x, slot, xs[s]); end
      step();
      tests++; if (an !== ans[s]) begin fails++; $display("FAIL %s_lit%0d: got an=%b want %b", tag, s, an, ans[s]); end
      step(); step();
      tests++; if (an !== ans[s]) begin fails++; $display("FAIL %s_end%0d: got an=%b want %b", tag, s, an, ans[s]); end
    end
  endtask

  task automatic test_lz_blank();
    lz_frame(16'h0005, "lz5");
    step();
    lz_frame(16'h0000, "lz0");
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full_frame();
    test_midslot_load();
    test_load_tick();
    test_en_drop();
    test_async_reset();
`ifdef SEG_SCAN_LZ_BLANK_EN
    test_lz_blank();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
